// File: rtl/stream_arb_mux.sv
// rtl/stream_arb_mux.sv - round-robin N-channel stream mux with registered output stage
// Define STREAM_ARB_MUX_LOCK_EN to hold the grant on one channel for a whole packet.
module stream_arb_mux #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  in_data,
  input  logic [NUM_CH-1:0]              in_valid,
  input  logic [NUM_CH-1:0]              in_last,
  output logic [NUM_CH-1:0]              in_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_valid,
  output logic                           out_last,
  output logic [SEL_W-1:0]               out_sel,
  input  logic                           out_ready
);

  localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH-1);

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] i);
    return (i == LAST_CH) ? '0 : i + SEL_W'(1);
  endfunction

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic [SEL_W-1:0]  rr_g, g;
  logic [SEL_W:0]    idx;
  logic              rr_valid, grant_valid, load, accept;

  // Walk the search order backwards so the channel closest to ptr wins.
  always_comb begin
    rr_g     = '0;
    rr_valid = 1'b0;
    idx      = '0;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (SEL_W+1)'(k);
      if (idx >= NUM_CH_W) idx = idx - NUM_CH_W;
      if (in_valid[idx[SEL_W-1:0]]) begin
        rr_g     = idx[SEL_W-1:0];
        rr_valid = 1'b1;
      end
    end
  end

`ifdef STREAM_ARB_MUX_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t           state_q, state_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;

  always_comb begin
    g           = rr_g;
    grant_valid = rr_valid;
    if (state_q == LOCKED) begin
      g           = lock_ch_q;
      grant_valid = in_valid[lock_ch_q];
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    ptr_d     = ptr_q;
    if (accept) begin
      if (in_last[g]) begin
        state_d = ARB;
        ptr_d   = wrap_inc(g);
      end else if (state_q == ARB) begin
        state_d   = LOCKED;
        lock_ch_d = g;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`else
  assign g           = rr_g;
  assign grant_valid = rr_valid;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = wrap_inc(g);
  end
`endif

  // rst_n gates load so no channel sees ready while the block is held in reset.
  assign load   = rst_n && (!out_valid_q || out_ready);
  assign accept = load && grant_valid;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept && (g == SEL_W'(i))) in_ready[i] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (load) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = in_data[g];
        out_last_d = in_last[g];
        out_sel_d  = g;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// tb/tb_stream_arb_mux.sv - scoreboard bench for stream_arb_mux
// Expected order per scenario depends on STREAM_ARB_MUX_LOCK_EN.
module tb_stream_arb_mux;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  typedef struct packed {logic [7:0] delay; logic last; logic [7:0] data;} beat_t;
  typedef struct packed {logic [2:0] sel; logic last; logic [7:0] data;} exp_t;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [NUM_CH-1:0][DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]             in_valid, in_last, in_ready;
  logic [DATA_W-1:0]             out_data;
  logic                          out_valid, out_last, out_ready;
  logic [SEL_W-1:0]              out_sel;

  beat_t chq [NUM_CH][$];
  exp_t  expq [$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  stream_arb_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_beat(input int ch, input logic [7:0] data, input logic last,
                           input logic [7:0] delay);
    beat_t b;
    b.delay = delay;
    b.last  = last;
    b.data  = data;
    chq[ch].push_back(b);
  endtask

  task automatic exp_beat(input int ch, input logic [7:0] data, input logic last);
    exp_t e;
    e.sel  = 3'(ch);
    e.last = last;
    e.data = data;
    expq.push_back(e);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_CH; i++) if (chq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      tick();
      done = all_empty() && (expq.size() == 0) && !out_valid;
    end
    chk(name, 32'(done), 32'd1);
    if (!done) begin
      for (int i = 0; i < NUM_CH; i++) chq[i].delete();
      expq.delete();
    end
  endtask

  // Producer model: presents each channel's head beat, pops it when a handshake is seen.
  initial begin : driver
    logic [NUM_CH-1:0] fire;
    beat_t hd;
    in_valid = '0;
    in_last  = '0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      fire = in_valid & in_ready;
      if (!rst_n) chk("ready_in_reset", 32'(in_ready), 32'd0);
      else begin
        chk("ready_onehot_subset",
            32'(($countones(in_ready) <= 1) && ((in_ready & ~in_valid) == '0)), 32'd1);
        if (out_valid && !out_ready) chk("ready_during_stall", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (fire[i] && chq[i].size() != 0) void'(chq[i].pop_front());
        in_valid[i] = 1'b0;
        if (chq[i].size() != 0) begin
          hd = chq[i][0];
          if (hd.delay != 8'd0) begin
            hd.delay = hd.delay - 8'd1;
            chq[i][0] = hd;
          end else begin
            in_valid[i] = 1'b1;
            in_data[i]  = hd.data;
            in_last[i]  = hd.last;
          end
        end
      end
    end
  end

  initial begin : monitor
    exp_t        e;
    logic        prev_stall;
    logic [12:0] prev;
    prev_stall = 1'b0;
    prev       = '0;
    forever begin
      @(negedge clk);
      if (rst_n && prev_stall)
        chk("hold_on_stall", 32'({out_valid, out_last, out_sel, out_data}), 32'(prev));
      prev_stall = rst_n && out_valid && !out_ready;
      prev       = {out_valid, out_last, out_sel, out_data};
      if (rst_n && out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got sel %0d data %0h with nothing expected at %0t",
                   out_sel, out_data, $time);
        end else begin
          e = expq.pop_front();
          chk("out_beat", 32'({out_sel, out_last, out_data}), 32'(e));
        end
      end
    end
  end

  initial begin : main
    int first, last, cnt;
    rst_n     = 1'b0;
    out_ready = 1'b1;

    // Reset with every channel valid; ch0 must win first.
    for (int i = 0; i < NUM_CH; i++) begin
      push_beat(i, 8'(i*16 + 1), 1'b1, 8'd0);
      exp_beat(i, 8'(i*16 + 1), 1'b1);
    end
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant_ch0", 32'(in_ready), 32'h01);
    @(negedge clk);
    chk("first_out_ch0", 32'({out_valid, out_sel}), 32'h8);
    wait_drain("t1_drained", 60);

    // Every channel valid, two single-beat packets each: 0..7,0..7 back to back.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_CH; i++) begin
        push_beat(i, 8'(i*16 + 2 + r), 1'b1, 8'd0);
        exp_beat(i, 8'(i*16 + 2 + r), 1'b1);
      end
    first = -1;
    last  = -1;
    cnt   = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
    end
    chk("t2_beat_count", 32'(cnt), 32'd16);
    chk("t2_no_bubble", 32'(last - first + 1), 32'd16);
    wait_drain("t2_drained", 40);

    // Move ptr to 4, then only ch3 and ch6 compete.
    push_beat(3, 8'h3A, 1'b1, 8'd0);
    exp_beat(3, 8'h3A, 1'b1);
    wait_drain("t3a_drained", 30);
    push_beat(3, 8'h3B, 1'b1, 8'd0);
    push_beat(3, 8'h3C, 1'b1, 8'd0);
    push_beat(6, 8'h6B, 1'b1, 8'd0);
    push_beat(6, 8'h6C, 1'b1, 8'd0);
    exp_beat(6, 8'h6B, 1'b1);
    exp_beat(3, 8'h3B, 1'b1);
    exp_beat(6, 8'h6C, 1'b1);
    exp_beat(3, 8'h3C, 1'b1);
    wait_drain("t3b_drained", 30);

    // Backpressure for 5 cycles while ch1/ch2 alternate (ptr starts at 4).
    for (int b = 0; b < 4; b++) push_beat(1, 8'(8'h11 + b), 1'b1, 8'd0);
    for (int b = 0; b < 3; b++) push_beat(2, 8'(8'h21 + b), 1'b1, 8'd0);
    exp_beat(1, 8'h11, 1'b1);
    exp_beat(2, 8'h21, 1'b1);
    exp_beat(1, 8'h12, 1'b1);
    exp_beat(2, 8'h22, 1'b1);
    exp_beat(1, 8'h13, 1'b1);
    exp_beat(2, 8'h23, 1'b1);
    exp_beat(1, 8'h14, 1'b1);
    tick();
    tick();
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    wait_drain("t4_drained", 40);

    // ch2 4-beat packet with a 2-cycle gap before beat 3; ch5 valid throughout (ptr=2).
    push_beat(2, 8'h24, 1'b0, 8'd0);
    push_beat(2, 8'h25, 1'b0, 8'd0);
    push_beat(2, 8'h26, 1'b0, 8'd2);
    push_beat(2, 8'h27, 1'b1, 8'd0);
    push_beat(5, 8'h51, 1'b1, 8'd0);
    push_beat(5, 8'h52, 1'b1, 8'd0);
`ifdef STREAM_ARB_MUX_LOCK_EN
    exp_beat(2, 8'h24, 1'b0);
    exp_beat(2, 8'h25, 1'b0);
    exp_beat(2, 8'h26, 1'b0);
    exp_beat(2, 8'h27, 1'b1);
    exp_beat(5, 8'h51, 1'b1);
    exp_beat(5, 8'h52, 1'b1);
`else
    exp_beat(2, 8'h24, 1'b0);
    exp_beat(5, 8'h51, 1'b1);
    exp_beat(2, 8'h25, 1'b0);
    exp_beat(5, 8'h52, 1'b1);
    exp_beat(2, 8'h26, 1'b0);
    exp_beat(2, 8'h27, 1'b1);
`endif
    wait_drain("t5_drained", 40);

    // Reset while beat 2 of a ch1 packet sits in the output register.
    push_beat(1, 8'h1A, 1'b0, 8'd0);
    push_beat(1, 8'h1B, 1'b0, 8'd0);
    push_beat(1, 8'h1C, 1'b0, 8'd0);
    push_beat(1, 8'h1D, 1'b1, 8'd0);
    exp_beat(1, 8'h1A, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_drops_beat", 32'(out_valid), 32'd0);
    chq[1].delete();
    push_beat(0, 8'h0E, 1'b1, 8'd0);
    push_beat(4, 8'h4E, 1'b1, 8'd0);
    exp_beat(0, 8'h0E, 1'b1);
    exp_beat(4, 8'h4E, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_out_idle_after_rst", 32'(out_valid), 32'd0);
    chk("t6_grant_after_rst", 32'(in_ready), 32'h01);
    wait_drain("t6_drained", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
